serial_add_ctrl: RTL and testbench



---
 rtl/serial_add_ctrl_pkg.sv | 14 +
 rtl/serial_add_ctrl_if.sv | 26 ++
 rtl/serial_add_ctrl_full_adder.sv | 13 +
 rtl/serial_add_ctrl.sv | 108 ++++++++++
 tb/tb_serial_add_ctrl.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// Shared types for the bit-serial adder controller: FSM state encoding and counter sizing.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Start/busy/done handshake and operand/result bus of serial_add_ctrl.
// Optional SERIAL_ADD_SUB_EN adds the sub request bit.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             CI;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;
`endif
  logic [WIDTH-1:0] S;
  logic             CO;
  logic             busy;
  logic             done;

`ifdef SERIAL_ADD_SUB_EN
  modport master (output start, A, B, CI, sub, input S, CO, busy, done);
  modport slave  (input start, A, B, CI, sub, output S, CO, busy, done);
`else
  modport master (output start, A, B, CI, input S, CO, busy, done);
  modport slave  (input start, A, B, CI, output S, CO, busy, done);
`endif

endinterface

// File: rtl/serial_add_ctrl_full_adder.sv
// One-bit full adder cell, time-shared by serial_add_ctrl.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic CI,
  output logic S,
  output logic CO
);

  assign S  = A ^ B ^ CI;
  assign CO = (A & B) | (CI & (A ^ B));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: one full_adder cell, LSB first, start/busy/done handshake.
// Optional SERIAL_ADD_SUB_EN enables subtraction (A-B) through the sub request bit.
//
// state | meaning
// IDLE  | waiting for start; S/CO hold the last result
// RUN   | one operand bit pair processed per edge, WIDTH edges total
// DONE  | one-cycle done pulse, S/CO valid
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic               clk,
  input logic               rst,
  serial_add_ctrl_if.slave  bus
);

  localparam int CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             carry_q, carry_d;
  logic             fa_s, fa_co;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

`ifdef SERIAL_ADD_SUB_EN
  // Two's-complement subtract: A + ~B + 1; final carry=1 means no borrow.
  assign b_load = bus.sub ? ~bus.B : bus.B;
  assign c_load = bus.sub ? 1'b1 : bus.CI;
`else
  assign b_load = bus.B;
  assign c_load = bus.CI;
`endif

  full_adder u_fa (
    .A  (opa_q[0]),
    .B  (opb_q[0]),
    .CI (carry_q),
    .S  (fa_s),
    .CO (fa_co)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      s_q     <= s_d;
      carry_q <= carry_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    s_d     = s_q;
    carry_d = carry_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          opa_d   = bus.A;
          opb_d   = b_load;
          carry_d = c_load;
          cnt_d   = '0;
          s_d     = '0;
        end
      end
      RUN: begin
        s_d     = {fa_s, s_q[WIDTH-1:1]};
        opa_d   = {1'b0, opa_q[WIDTH-1:1]};
        opb_d   = {1'b0, opb_q[WIDTH-1:1]};
        carry_d = fa_co;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.S    = s_q;
  assign bus.CO   = carry_q;
  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == DONE);

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: stimulus pushes hand-computed results, a monitor pops on done.
module tb_serial_add_ctrl;

  localparam int WIDTH = 8;

  typedef struct {
    logic [WIDTH-1:0] s;
    logic             co;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   n_done = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done=1 with no pending result at %0t", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result_S", 32'(bus.S), 32'(e.s));
        check("result_CO", 32'(bus.CO), 32'(e.co));
        n_done++;
      end
    end
  end

  // Caller guarantees the DUT is idle; accept happens on the next edge (edge 0).
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic ci,
                        input logic [WIDTH-1:0] exp_s, input logic exp_co);
    exp_t e;
    bus.A     = a;
    bus.B     = b;
    bus.CI    = ci;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    e.s  = exp_s;
    e.co = exp_co;
    exp_q.push_back(e);
    bus.A  = ~a;
    bus.B  = ~b;
    bus.CI = ~ci;
    for (int k = 1; k <= WIDTH + 1; k++) begin
      tick();
      check("busy_timing", 32'(bus.busy), 32'(k <= WIDTH));
      check("done_timing", 32'(bus.done), 32'(k == WIDTH));
    end
    check("hold_S", 32'(bus.S), 32'(exp_s));
    check("hold_CO", 32'(bus.CO), 32'(exp_co));
  endtask

  initial begin
    logic [WIDTH-1:0] va[3];
    logic [WIDTH-1:0] vb[3];
    logic             vc[3];
    logic [WIDTH-1:0] vs[3];
    logic             vco[3];
    int               done_before;
    exp_t             e;

    rst       = 1'b1;
    bus.start = 1'b1;
    bus.A     = 8'h3C;
    bus.B     = 8'h05;
    bus.CI    = 1'b1;
`ifdef SERIAL_ADD_SUB_EN
    bus.sub   = 1'b0;
`endif
    tick();
    tick();
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_S", 32'(bus.S), 32'd0);
    check("rst_CO", 32'(bus.CO), 32'd0);
    bus.start = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("idle_S", 32'(bus.S), 32'd0);

    run_op(8'h3C, 8'h05, 1'b0, 8'h41, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

    // Start held high: accepts land every WIDTH+2 edges, other cycles carry decoy operands.
    va[0] = 8'h12; vb[0] = 8'h34; vc[0] = 1'b0; vs[0] = 8'h46; vco[0] = 1'b0;
    va[1] = 8'h80; vb[1] = 8'h80; vc[1] = 1'b1; vs[1] = 8'h01; vco[1] = 1'b1;
    va[2] = 8'hAA; vb[2] = 8'h55; vc[2] = 1'b1; vs[2] = 8'h00; vco[2] = 1'b1;
    done_before = n_done;
    bus.start = 1'b1;
    for (int c = 0; c < 3 * (WIDTH + 2); c++) begin
      if (c % (WIDTH + 2) == 0) begin
        bus.A  = va[c / (WIDTH + 2)];
        bus.B  = vb[c / (WIDTH + 2)];
        bus.CI = vc[c / (WIDTH + 2)];
        e.s  = vs[c / (WIDTH + 2)];
        e.co = vco[c / (WIDTH + 2)];
        exp_q.push_back(e);
      end else begin
        bus.A  = 8'hFF;
        bus.B  = 8'hFF;
        bus.CI = 1'b1;
      end
      tick();
      if (c % (WIDTH + 2) == 0) begin
        check("b2b_busy_after_accept", 32'(bus.busy), 32'd1);
      end
    end
    bus.start = 1'b0;
    tick();
    check("b2b_done_count", 32'(n_done - done_before), 32'd3);
    check("b2b_idle", 32'(bus.busy), 32'd0);

    // Abort with reset sampled on edge 4 of a run.
    bus.A     = 8'h3C;
    bus.B     = 8'h05;
    bus.CI    = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_S", 32'(bus.S), 32'd0);
    check("abort_CO", 32'(bus.CO), 32'd0);
    for (int k = 0; k < WIDTH + 4; k++) tick();
    check("abort_no_done", 32'(bus.done), 32'd0);
    run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
    bus.sub = 1'b1;
    run_op(8'h10, 8'h01, 1'b0, 8'h0F, 1'b1);
    run_op(8'h01, 8'h02, 1'b0, 8'hFF, 1'b0);
    bus.sub = 1'b0;
`endif

    tick();
    tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
